sync_ddio_align_ctrl: RTL and testbench



---
 rtl/sync_ddio_pkg.sv | 25 ++
 rtl/sync_ddio_slip.sv | 34 +++
 rtl/sync_ddio_align_ctrl.sv | 144 ++++++++++++++
 tb/tb_sync_ddio_align_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sync_ddio_pkg.sv
// rtl/sync_ddio_pkg.sv - shared state encoding and counter sizing for the ddio controllers
package sync_ddio_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TRAIN  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_LOCKED = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_TRAIN  = ST_TRAIN,
    S_SETTLE = ST_SETTLE,
    S_LOCKED = ST_LOCKED,
    S_FAIL   = ST_FAIL
  } state_t;

  // Bits needed to hold 0..limit; never narrower than one bit so a zero limit still elaborates.
  function automatic int cnt_w(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_ddio_slip.sv
// rtl/sync_ddio_slip.sv - registered half-word slip mux for the ddio input pair
module sync_ddio_slip #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          slip,
  input  logic [DW-1:0] q0,
  input  logic [DW-1:0] q1,
  output logic [DW-1:0] d0,
  output logic [DW-1:0] d1
);

  logic [DW-1:0] q1_prev;

  // With slip set, the pair is rebuilt from last cycle's q1 and this cycle's q0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_prev <= '0;
      d0      <= '0;
      d1      <= '0;
    end else begin
      q1_prev <= q1;
      if (slip) begin
        d0 <= q1_prev;
        d1 <= q0;
      end else begin
        d0 <= q0;
        d1 <= q1;
      end
    end
  end

endmodule

// File: rtl/sync_ddio_align_ctrl.sv
// rtl/sync_ddio_align_ctrl.sv - training, lock and lock-loss controller for the ddio input pair
module sync_ddio_align_ctrl
  import sync_ddio_pkg::*;
#(
  parameter int            DW         = 1,
  parameter logic [DW-1:0] P0         = {DW{1'b1}},
  parameter logic [DW-1:0] P1         = {DW{1'b0}},
  parameter int            MATCH_CNT  = 16,
  parameter int            SETTLE_CNT = 4,
  parameter int            MAX_SLIP   = 3,
  parameter int            MISS_LIMIT = 4
) (
  input  logic          c_x1,
  input  logic          arst_c_x1,
  input  logic          train_start,
  input  logic          monitor,
  input  logic [DW-1:0] q0,
  input  logic [DW-1:0] q1,
  output logic [DW-1:0] d0,
  output logic [DW-1:0] d1,
  output logic          slip,
  output logic          busy,
  output logic          locked,
  output logic          fail,
  output logic          lost
);

  localparam int MW = cnt_w(MATCH_CNT);
  localparam int SW = cnt_w(MAX_SLIP);
  localparam int TW = cnt_w(SETTLE_CNT);
  localparam int LW = cnt_w(MISS_LIMIT);

  state_t        state_q, state_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] stcnt_q, stcnt_d;
  logic [LW-1:0] miss_q, miss_d;
  logic          slip_q, slip_d;
  logic          lost_d;
  logic          match;

  sync_ddio_slip #(.DW(DW)) u_slip (
    .clk  (c_x1),
    .rst  (arst_c_x1),
    .slip (slip_q),
    .q0   (q0),
    .q1   (q1),
    .d0   (d0),
    .d1   (d1)
  );

  assign match = (d0 == P0) && (d1 == P1);
  assign slip  = slip_q;

  // Next-state and counter updates; transitions fire exactly at each limit so nothing wraps.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    scnt_d  = scnt_q;
    stcnt_d = stcnt_q;
    miss_d  = miss_q;
    slip_d  = slip_q;
    lost_d  = 1'b0;
    case (state_q)
      S_IDLE, S_FAIL, S_LOCKED: begin
        if (train_start) begin
          state_d = S_TRAIN;
          mcnt_d  = '0;
          scnt_d  = '0;
          miss_d  = '0;
          slip_d  = 1'b0;
        end else if (state_q == S_LOCKED) begin
          if (!monitor || match) begin
            miss_d = '0;
          end else if (miss_q == LW'(MISS_LIMIT - 1)) begin
            state_d = S_TRAIN;
            lost_d  = 1'b1;
            miss_d  = '0;
            mcnt_d  = '0;
            scnt_d  = '0;
          end else begin
            miss_d = miss_q + LW'(1);
          end
        end
      end
      S_TRAIN: begin
        if (match) begin
          mcnt_d = mcnt_q + MW'(1);
          if (mcnt_q == MW'(MATCH_CNT - 1)) begin
            state_d = S_LOCKED;
            miss_d  = '0;
          end
        end else begin
          mcnt_d = '0;
          if (scnt_q == SW'(MAX_SLIP)) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_SETTLE;
            slip_d  = ~slip_q;
            scnt_d  = scnt_q + SW'(1);
            stcnt_d = '0;
          end
        end
      end
      S_SETTLE: begin
        if (stcnt_q == TW'(SETTLE_CNT - 1)) begin
          state_d = S_TRAIN;
          mcnt_d  = '0;
        end else begin
          stcnt_d = stcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and status flags; flags are taken from the next state so they align with it.
  always_ff @(posedge c_x1 or posedge arst_c_x1) begin
    if (arst_c_x1) begin
      state_q <= S_IDLE;
      mcnt_q  <= '0;
      scnt_q  <= '0;
      stcnt_q <= '0;
      miss_q  <= '0;
      slip_q  <= 1'b0;
      busy    <= 1'b0;
      locked  <= 1'b0;
      fail    <= 1'b0;
      lost    <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      scnt_q  <= scnt_d;
      stcnt_q <= stcnt_d;
      miss_q  <= miss_d;
      slip_q  <= slip_d;
      busy    <= (state_d == S_TRAIN) || (state_d == S_SETTLE);
      locked  <= (state_d == S_LOCKED);
      fail    <= (state_d == S_FAIL);
      lost    <= lost_d;
    end
  end

endmodule

// File: tb/tb_sync_ddio_align_ctrl.sv
// tb/tb_sync_ddio_align_ctrl.sv - directed vector bench for sync_ddio_align_ctrl
module tb_sync_ddio_align_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ts  = 1'b0;
  logic       mon = 1'b0;
  logic [1:0] q0  = 2'b00;
  logic [1:0] q1  = 2'b00;
  logic [1:0] d0, d1;
  logic       slip, busy, locked, fail, lost;

  int checks = 0;
  int errors = 0;

  sync_ddio_align_ctrl #(
    .DW(2), .P0(2'b10), .P1(2'b01), .MATCH_CNT(4),
    .SETTLE_CNT(2), .MAX_SLIP(3), .MISS_LIMIT(2)
  ) dut (
    .c_x1(clk), .arst_c_x1(rst), .train_start(ts), .monitor(mon),
    .q0(q0), .q1(q1), .d0(d0), .d1(d1),
    .slip(slip), .busy(busy), .locked(locked), .fail(fail), .lost(lost)
  );

  always #5 clk = ~clk;

  // ctl = {rst, train_start, monitor}; st = {slip, busy, locked, fail, lost}
  typedef struct {
    logic [2:0] ctl;
    logic [1:0] q0, q1, d0, d1;
    logic [4:0] st;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [2:0] c, input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] x, input logic [1:0] y, input logic [4:0] s);
    vec_t v;
    v.ctl = c; v.q0 = a; v.q1 = b; v.d0 = x; v.d1 = y; v.st = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // aligned stream, then monitor low ignores bad words while locked
    vecs[0]  = mk(3'b100, 2'b10, 2'b01, 2'b00, 2'b00, 5'b00000);
    vecs[1]  = mk(3'b000, 2'b10, 2'b01, 2'b10, 2'b01, 5'b00000);
    vecs[2]  = mk(3'b010, 2'b10, 2'b01, 2'b10, 2'b01, 5'b01000);
    vecs[3]  = mk(3'b000, 2'b10, 2'b01, 2'b10, 2'b01, 5'b01000);
    vecs[4]  = mk(3'b000, 2'b10, 2'b01, 2'b10, 2'b01, 5'b01000);
    vecs[5]  = mk(3'b000, 2'b10, 2'b01, 2'b10, 2'b01, 5'b01000);
    vecs[6]  = mk(3'b000, 2'b10, 2'b01, 2'b10, 2'b01, 5'b00100);
    vecs[7]  = mk(3'b000, 2'b00, 2'b01, 2'b00, 2'b01, 5'b00100);
    vecs[8]  = mk(3'b000, 2'b00, 2'b01, 2'b00, 2'b01, 5'b00100);
    vecs[9]  = mk(3'b000, 2'b00, 2'b01, 2'b00, 2'b01, 5'b00100);
    // half-word offset stream: one slip, two settle cycles, four matches
    vecs[10] = mk(3'b100, 2'b01, 2'b10, 2'b00, 2'b00, 5'b00000);
    vecs[11] = mk(3'b000, 2'b01, 2'b10, 2'b01, 2'b10, 5'b00000);
    vecs[12] = mk(3'b010, 2'b01, 2'b10, 2'b01, 2'b10, 5'b01000);
    vecs[13] = mk(3'b000, 2'b01, 2'b10, 2'b01, 2'b10, 5'b11000);
    vecs[14] = mk(3'b000, 2'b01, 2'b10, 2'b10, 2'b01, 5'b11000);
    vecs[15] = mk(3'b000, 2'b01, 2'b10, 2'b10, 2'b01, 5'b11000);
    vecs[16] = mk(3'b000, 2'b01, 2'b10, 2'b10, 2'b01, 5'b11000);
    vecs[17] = mk(3'b000, 2'b01, 2'b10, 2'b10, 2'b01, 5'b11000);
    vecs[18] = mk(3'b000, 2'b01, 2'b10, 2'b10, 2'b01, 5'b11000);
    vecs[19] = mk(3'b000, 2'b01, 2'b10, 2'b10, 2'b01, 5'b10100);

    #1;
    chk("reset status", {d0, d1, slip, busy, locked, fail, lost}, 9'd0);

    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].ctl[2];
      ts  = vecs[i].ctl[1];
      mon = vecs[i].ctl[0];
      q0  = vecs[i].q0;
      q1  = vecs[i].q1;
      step();
      chk($sformatf("vec%0d d0", i), d0, vecs[i].d0);
      chk($sformatf("vec%0d d1", i), d1, vecs[i].d1);
      chk($sformatf("vec%0d status", i), {slip, busy, locked, fail, lost}, vecs[i].st);
    end
    chk("offset scnt", dut.scnt_q, 1);
    ts = 1'b0;

    // constant zero stream: three slips then FAIL, held until restart
    do_reset();
    q0 = 2'b00; q1 = 2'b00; ts = 1'b1;
    step();
    ts = 1'b0;
    chk("zero busy", busy, 1);
    repeat (9) step();
    chk("zero fail before", fail, 0);
    step();
    chk("zero fail", {busy, locked, fail, slip}, 4'b0011);
    repeat (5) step();
    chk("zero fail held", fail, 1);
    ts = 1'b1;
    step();
    ts = 1'b0;
    chk("restart from fail", {busy, locked, fail, slip}, 4'b1000);

    // lock with monitor on, single bad word, then two bad words
    do_reset();
    q0 = 2'b10; q1 = 2'b01; mon = 1'b1; ts = 1'b1;
    step();
    ts = 1'b0;
    repeat (4) step();
    chk("mon locked", locked, 1);
    q0 = 2'b00;
    step();
    q0 = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("single bad k%0d", k), {locked, lost, busy}, 3'b100);
    end
    q0 = 2'b00;
    step();
    step();
    q0 = 2'b10;
    chk("before loss", {locked, lost}, 2'b10);
    step();
    chk("loss pulse", {locked, lost, busy, slip}, 4'b0110);
    step();
    chk("loss one cycle", {lost, busy}, 2'b01);
    repeat (2) step();
    chk("relock pending", locked, 0);
    step();
    chk("relock", {locked, busy, lost}, 3'b100);
    mon = 1'b0;

    // asynchronous reset during SETTLE
    do_reset();
    q0 = 2'b01; q1 = 2'b10; ts = 1'b1;
    step();
    ts = 1'b0;
    step();
    chk("settle entry", {slip, busy}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async reset", {d0, d1, slip, busy, locked, fail, lost}, 9'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("idle after reset", {busy, locked, fail}, 3'b000);

    // train_start repeated while training is ignored
    q0 = 2'b10; q1 = 2'b01; ts = 1'b1;
    step();
    step();
    step();
    ts = 1'b0;
    chk("retrain mcnt", dut.mcnt_q, 2);
    chk("retrain scnt", dut.scnt_q, 0);
    step();
    chk("retrain not yet", locked, 0);
    step();
    chk("retrain locked", {locked, busy}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
